// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, control bundle widths and the control decoder.
package pipeline_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_AW    = 5;
    localparam int DATA_W    = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    typedef struct packed {
        logic [WB_W-1:0] wb;  // {regwrite, memtoreg}
        logic [M_W-1:0]  m;   // {branch, memread, memwrite}
        logic [EX_W-1:0] ex;  // {regdst, aluop[1:0], alusrc}
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = CTRL_NOP;
        case (opcode)
            OP_RTYPE: c = '{wb: 2'b10, m: 3'b000, ex: 4'b1100};
            OP_LW:    c = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
            OP_SW:    c = '{wb: 2'b00, m: 3'b001, ex: 4'b0001};
            OP_BEQ:   c = '{wb: 2'b00, m: 3'b100, ex: 4'b0010};
            default:  c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two async read ports, one sync write port, r0 hardwired to zero,
// write-through bypass so a write-back and a dependent decode can share a cycle.
module register_file
    import pipeline_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REG_AW-1:0] i_rs_addr,
    input  logic [REG_AW-1:0] i_rt_addr,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_regs [REG_COUNT];
    logic              w_write;

    assign w_write = i_we && (i_waddr != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // w_write already excludes r0, so the bypass can never leak data onto address 0.
    always_comb begin
        o_rs_data = '0;
        o_rt_data = '0;
        if (i_rs_addr != '0) begin
            o_rs_data = (w_write && (i_waddr == i_rs_addr)) ? i_wdata : r_regs[i_rs_addr];
        end
        if (i_rt_addr != '0) begin
            o_rt_data = (w_write && (i_waddr == i_rt_addr)) ? i_wdata : r_regs[i_rt_addr];
        end
    end

endmodule

// File: rtl/final_id_stage.sv
// Instruction-decode stage: control decode, register read, sign extension and the ID/EX latch.
module final_id_stage
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       if_id_npc,
    input  logic [31:0]       if_id_instr,
    input  logic              ex_mem_pcsrc,
    input  logic              mem_wb_regwrite,
    input  logic [4:0]        mem_wb_write_reg,
    input  logic [31:0]       mem_wb_write_data,
    output logic [WB_W-1:0]   id_ex_wb,
    output logic [M_W-1:0]    id_ex_m,
    output logic [EX_W-1:0]   id_ex_ex,
    output logic [31:0]       id_ex_npc,
    output logic [31:0]       id_ex_rd1,
    output logic [31:0]       id_ex_rd2,
    output logic [31:0]       id_ex_imm,
    output logic [4:0]        id_ex_rt,
    output logic [4:0]        id_ex_rd
);

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    ctrl_t       w_ctrl;

    ctrl_t       r_ctrl;
    logic [31:0] r_npc;
    logic [31:0] r_rd1;
    logic [31:0] r_rd2;
    logic [31:0] r_imm;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;

    assign w_opcode = if_id_instr[31:26];
    assign w_rs     = if_id_instr[25:21];
    assign w_rt     = if_id_instr[20:16];
    assign w_rd     = if_id_instr[15:11];
    assign w_imm    = if_id_instr[15:0];

    // A taken branch turns this slot into a bubble; data fields still load as don't-care.
    always_comb begin
        w_ctrl = CTRL_NOP;
        if (!ex_mem_pcsrc) begin
            w_ctrl = decode_ctrl(w_opcode);
        end
    end

    register_file u_register_file (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_rs_addr (w_rs),
        .i_rt_addr (w_rt),
        .o_rs_data (w_rd1),
        .o_rt_data (w_rd2),
        .i_we      (mem_wb_regwrite),
        .i_waddr   (mem_wb_write_reg),
        .i_wdata   (mem_wb_write_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl <= CTRL_NOP;
            r_npc  <= '0;
            r_rd1  <= '0;
            r_rd2  <= '0;
            r_imm  <= '0;
            r_rt   <= '0;
            r_rd   <= '0;
        end else begin
            r_ctrl <= w_ctrl;
            r_npc  <= if_id_npc;
            r_rd1  <= w_rd1;
            r_rd2  <= w_rd2;
            r_imm  <= {{16{w_imm[15]}}, w_imm};
            r_rt   <= w_rt;
            r_rd   <= w_rd;
        end
    end

    assign id_ex_wb  = r_ctrl.wb;
    assign id_ex_m   = r_ctrl.m;
    assign id_ex_ex  = r_ctrl.ex;
    assign id_ex_npc = r_npc;
    assign id_ex_rd1 = r_rd1;
    assign id_ex_rd2 = r_rd2;
    assign id_ex_imm = r_imm;
    assign id_ex_rt  = r_rt;
    assign id_ex_rd  = r_rd;

endmodule

// File: tb/tb_final_id_stage.sv
// Self-checking bench for final_id_stage: directed scenarios plus random traffic against a model.
module tb_final_id_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] if_id_npc = '0;
    logic [31:0] if_id_instr = '0;
    logic        ex_mem_pcsrc = 1'b0;
    logic        mem_wb_regwrite = 1'b0;
    logic [4:0]  mem_wb_write_reg = '0;
    logic [31:0] mem_wb_write_data = '0;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_m;
    logic [3:0]  id_ex_ex;
    logic [31:0] id_ex_npc;
    logic [31:0] id_ex_rd1;
    logic [31:0] id_ex_rd2;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_rd;

    int errors = 0;
    int checks = 0;

    logic [31:0]  mregs [32];
    logic [178:0] e_all;

    always #5 clk = ~clk;

    final_id_stage dut (
        .clk               (clk),
        .reset             (reset),
        .if_id_npc         (if_id_npc),
        .if_id_instr       (if_id_instr),
        .ex_mem_pcsrc      (ex_mem_pcsrc),
        .mem_wb_regwrite   (mem_wb_regwrite),
        .mem_wb_write_reg  (mem_wb_write_reg),
        .mem_wb_write_data (mem_wb_write_data),
        .id_ex_wb          (id_ex_wb),
        .id_ex_m           (id_ex_m),
        .id_ex_ex          (id_ex_ex),
        .id_ex_npc         (id_ex_npc),
        .id_ex_rd1         (id_ex_rd1),
        .id_ex_rd2         (id_ex_rd2),
        .id_ex_imm         (id_ex_imm),
        .id_ex_rt          (id_ex_rt),
        .id_ex_rd          (id_ex_rd)
    );

    function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 9'b10_000_1100;
            6'h23:   return 9'b11_010_0001;
            6'h2B:   return 9'b00_001_0001;
            6'h04:   return 9'b00_100_0010;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (mem_wb_regwrite && mem_wb_write_reg == a) return mem_wb_write_data;
        return mregs[a];
    endfunction

    function automatic logic [178:0] dut_all();
        return {id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_rd1, id_ex_rd2, id_ex_imm,
                id_ex_rt, id_ex_rd};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
    endtask

    // Drive one cycle of inputs at the falling edge, predict the latch, return #1 after the edge.
    task automatic apply(input logic [31:0] instr, input logic [31:0] npc, input logic pcsrc,
                         input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
        logic [8:0] c;
        @(negedge clk);
        if_id_instr       = instr;
        if_id_npc         = npc;
        ex_mem_pcsrc      = pcsrc;
        mem_wb_regwrite   = we;
        mem_wb_write_reg  = wreg;
        mem_wb_write_data = wdata;
        c = pcsrc ? 9'b0 : ref_ctrl(instr[31:26]);
        e_all = {c, npc, ref_read(instr[25:21]), ref_read(instr[20:16]),
                 {{16{instr[15]}}, instr[15:0]}, instr[20:16], instr[15:11]};
        @(posedge clk);
        if (we && wreg != 0) mregs[wreg] = wdata;
        #1;
    endtask

    task automatic test_reset();
        clear_model();
        reset = 1'b0;
        if_id_instr = 32'h8C22_0004;
        if_id_npc = 32'h0000_0040;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_all() !== '0) begin
            errors++;
            $display("FAIL reset_hold: got %h want 0", dut_all());
        end
        @(negedge clk);
        reset = 1'b1;
        apply(32'h8C22_0004, 32'h0000_0040, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if ({id_ex_wb, id_ex_m, id_ex_ex} !== 9'b11_010_0001) begin
            errors++;
            $display("FAIL reset_release_ctrl: got %b want 110100001",
                     {id_ex_wb, id_ex_m, id_ex_ex});
        end
        checks++;
        if (id_ex_imm !== 32'h0000_0004) begin
            errors++;
            $display("FAIL reset_release_imm: got %h want 00000004", id_ex_imm);
        end
    endtask

    task automatic test_writeback_rtype();
        apply(32'hFC00_0000, 32'h4, 1'b0, 1'b1, 5'd1, 32'h1234_5678);
        apply(32'hFC00_0000, 32'h8, 1'b0, 1'b1, 5'd2, 32'hFFFF_FFF0);
        apply(32'h0022_1820, 32'hC, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (id_ex_rd1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rtype_rd1: got %h want 12345678", id_ex_rd1);
        end
        checks++;
        if (id_ex_rd2 !== 32'hFFFF_FFF0) begin
            errors++;
            $display("FAIL rtype_rd2: got %h want fffffff0", id_ex_rd2);
        end
        checks++;
        if (id_ex_rd !== 5'd3 || id_ex_ex !== 4'b1100) begin
            errors++;
            $display("FAIL rtype_rd_ex: got rd=%0d ex=%b want rd=3 ex=1100", id_ex_rd, id_ex_ex);
        end
    endtask

    task automatic test_bypass();
        apply(32'h00A6_0000, 32'h10, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        checks++;
        if (id_ex_rd1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass_rd1: got %h want deadbeef", id_ex_rd1);
        end
    endtask

    task automatic test_reg0();
        apply(32'h0000_0000, 32'h14, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        checks++;
        if (id_ex_rd1 !== 32'h0) begin
            errors++;
            $display("FAIL reg0_same_cycle: got %h want 0", id_ex_rd1);
        end
        apply(32'h0001_0000, 32'h18, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (id_ex_rd1 !== 32'h0 || id_ex_rd2 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reg0_after: got rd1=%h rd2=%h want 0 12345678", id_ex_rd1, id_ex_rd2);
        end
    endtask

    task automatic test_flush_signext();
        apply(32'h1022_FFFF, 32'h1C, 1'b1, 1'b1, 5'd7, 32'h0BAD_F00D);
        checks++;
        if ({id_ex_wb, id_ex_m, id_ex_ex} !== 9'b0) begin
            errors++;
            $display("FAIL flush_ctrl: got %b want 0", {id_ex_wb, id_ex_m, id_ex_ex});
        end
        apply(32'h1022_FFFF, 32'h20, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (id_ex_m !== 3'b100 || id_ex_imm !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL beq_after_flush: got m=%b imm=%h want 100 ffffffff", id_ex_m, id_ex_imm);
        end
        apply(32'h00E0_0000, 32'h24, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (id_ex_rd1 !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL flush_write_commits: got %h want 0badf00d", id_ex_rd1);
        end
    endtask

    task automatic test_async_reset();
        apply(32'h8C22_8000, 32'h28, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (id_ex_wb !== 2'b11 || id_ex_rd1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL pre_async_reset: got wb=%b rd1=%h want 11 12345678", id_ex_wb, id_ex_rd1);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (dut_all() !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h want 0", dut_all());
        end
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        apply(32'h0022_0000, 32'h2C, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (id_ex_rd1 !== 32'h0 || id_ex_rd2 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_regs: got rd1=%h rd2=%h want 0 0", id_ex_rd1, id_ex_rd2);
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops [5];
        logic [5:0]  op;
        logic [31:0] instr;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h00;
        for (int n = 0; n < 300; n++) begin
            op = ops[$urandom_range(0, 4)];
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            instr = {op, 26'($urandom)};
            apply(instr, $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                  5'($urandom), $urandom);
            checks++;
            if (dut_all() !== e_all) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %h want %h", n, dut_all(), e_all);
            end
        end
    endtask

    initial begin
        test_reset();
        test_writeback_rtype();
        test_bypass();
        test_reg0();
        test_flush_signext();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
